rocc_mem_retry_queue: RTL and testbench

//  Sits between the vv_add accelerator memory port and the L1 D-cache RoCC port.

---
 rtl/rocc_mem_pkg.sv | 30 +++
 rtl/rocc_rr_pick.sv | 31 +++
 rtl/rocc_mem_retry_queue.sv | 214 +++++++++++++++++++++
 tb/tb_rocc_mem_retry_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rocc_mem_pkg.sv
// Shared types and constants for the RoCC memory retry queue.
// Field widths match the Rocket L1 D-cache RoCC memory interface.
package rocc_mem_pkg;

  localparam int ADDR_W = 40;
  localparam int TAG_W  = 10;
  localparam int CMD_W  = 5;
  localparam int TYP_W  = 3;
  localparam int DATA_W = 64;

  localparam logic [CMD_W-1:0] M_XRD = 5'd0;
  localparam logic [CMD_W-1:0] M_XWR = 5'd1;

  // Per-slot lifecycle: FREE -> ISSUE -> WAIT -> FREE, with WAIT -> ISSUE on nack.
  typedef enum logic [1:0] {
    FREE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } slot_state_t;

  // Everything needed to (re)issue a request and to answer the accelerator.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [CMD_W-1:0]  cmd;
    logic [TYP_W-1:0]  typ;
    logic [DATA_W-1:0] data;
  } slot_t;

endpackage

// File: rtl/rocc_rr_pick.sv
// Round-robin picker: returns a one-hot grant for the first asserted request
// found when scanning upward from start_i (inclusive), wrapping at N.
// N must be a power of two so the index wraps by natural overflow.
module rocc_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [N-1:0]         gnt_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  // Scan from the start position and keep the first hit.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = start_i + IW'(i);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rocc_mem_retry_queue.sv
// RoCC memory retry queue between the vv_add accelerator and the L1 D-cache.
// Holds up to NUM_ENTRIES outstanding requests, re-issues nacked ones, and
// maps the accelerator tag to a slot index on the cache side.
// Optional feature: define MEM_RETRY_TIMEOUT_EN to re-issue a slot that has
// waited TIMEOUT_CYCLES without any response (and flag err_o).
module rocc_mem_retry_queue
  import rocc_mem_pkg::*;
#(
  parameter int NUM_ENTRIES    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_req_valid_i,
  output logic              acc_req_ready_o,
  input  logic [ADDR_W-1:0] acc_req_addr_i,
  input  logic [TAG_W-1:0]  acc_req_tag_i,
  input  logic [CMD_W-1:0]  acc_req_cmd_i,
  input  logic [TYP_W-1:0]  acc_req_typ_i,
  input  logic [DATA_W-1:0] acc_req_data_i,
  output logic              acc_resp_valid_o,
  output logic [TAG_W-1:0]  acc_resp_tag_o,
  output logic [DATA_W-1:0] acc_resp_data_o,
  output logic              acc_resp_has_data_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [TAG_W-1:0]  mem_req_tag_o,
  output logic [CMD_W-1:0]  mem_req_cmd_o,
  output logic [TYP_W-1:0]  mem_req_typ_o,
  output logic [DATA_W-1:0] mem_req_data_o,
  output logic              mem_req_phys_o,
  input  logic              mem_resp_valid_i,
  input  logic [TAG_W-1:0]  mem_resp_tag_i,
  input  logic [DATA_W-1:0] mem_resp_data_i,
  input  logic              mem_resp_has_data_i,
  input  logic              mem_resp_nack_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int IW = $clog2(NUM_ENTRIES);

  if (NUM_ENTRIES < 2 || NUM_ENTRIES > 8 || (NUM_ENTRIES & (NUM_ENTRIES - 1)) != 0 ||
      TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("rocc_mem_retry_queue: NUM_ENTRIES must be 2, 4 or 8 and TIMEOUT_CYCLES >= 2");
  end

  slot_state_t       state_q [NUM_ENTRIES];
  slot_state_t       state_d [NUM_ENTRIES];
  slot_t             slot_q  [NUM_ENTRIES];
  slot_t             slot_d  [NUM_ENTRIES];
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              hold_q, hold_d;
  logic [IW-1:0]     hold_idx_q, hold_idx_d;
  logic              err_q, err_d;
  logic              resp_vld_q, resp_vld_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_has_data_q, resp_has_data_d;

  logic [NUM_ENTRIES-1:0] free_vec, issue_vec, busy_vec, pick_gnt, tmo_hit;
  logic [IW-1:0]          alloc_idx, pick_idx, gnt_idx, rsp_idx;
  logic                   accept, issue_hs, rsp_event, rsp_in_range, rsp_ok, rsp_stray;

  // Decode registered slot states into bit vectors.
  always_comb begin
    free_vec  = '0;
    issue_vec = '0;
    busy_vec  = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i]  = (state_q[i] == FREE);
      issue_vec[i] = (state_q[i] == ISSUE);
      busy_vec[i]  = (state_q[i] != FREE);
    end
  end

  // Lowest-index FREE slot receives the next accepted request.
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IW'(i);
    end
  end

  rocc_rr_pick #(
    .N (NUM_ENTRIES)
  ) u_pick (
    .req_i   (issue_vec),
    .start_i (ptr_q),
    .gnt_o   (pick_gnt)
  );

  // Encode the one-hot pick; a stalled request keeps its slot so the payload stays put.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (pick_gnt[i]) pick_idx = pick_idx | IW'(i);
    end
    gnt_idx = hold_q ? hold_idx_q : pick_idx;
  end

  // Classify the cache response: legal only for an in-range slot that is waiting.
  always_comb begin
    rsp_event    = mem_resp_valid_i | mem_resp_nack_i;
    rsp_in_range = (mem_resp_tag_i < TAG_W'(NUM_ENTRIES));
    rsp_idx      = mem_resp_tag_i[IW-1:0];
    rsp_ok       = rsp_event && rsp_in_range && (state_q[rsp_idx] == WAIT);
    rsp_stray    = rsp_event && !rsp_ok;
  end

`ifdef MEM_RETRY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] tmo_cnt_q [NUM_ENTRIES];
  logic [CW-1:0] tmo_cnt_d [NUM_ENTRIES];

  // Watchdog per slot: counts while in WAIT, reads zero on the first WAIT cycle.
  always_comb begin
    tmo_hit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      tmo_cnt_d[i] = (state_q[i] == WAIT) ? tmo_cnt_q[i] + CW'(1) : '0;
      tmo_hit[i]   = (state_q[i] == WAIT) && (tmo_cnt_q[i] == CW'(TIMEOUT_CYCLES - 1));
    end
  end

  // Watchdog counters are control state and clear on reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rst) tmo_cnt_q[i] <= '0;
      else     tmo_cnt_q[i] <= tmo_cnt_d[i];
    end
  end
`else
  // Without the watchdog a slot waits for its response indefinitely.
  always_comb begin
    tmo_hit = '0;
  end
`endif

  assign accept   = acc_req_valid_i & acc_req_ready_o;
  assign issue_hs = mem_req_valid_o & mem_req_ready_i;

  // Next-state for slots, arbitration pointer, error flag and response register.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      slot_d[i]  = slot_q[i];
      if (tmo_hit[i]) state_d[i] = ISSUE;
    end
    if (accept) begin
      state_d[alloc_idx] = ISSUE;
      slot_d[alloc_idx]  = '{addr: acc_req_addr_i, tag: acc_req_tag_i, cmd: acc_req_cmd_i,
                             typ: acc_req_typ_i, data: acc_req_data_i};
    end
    if (issue_hs) state_d[gnt_idx] = WAIT;
    // A real response outranks a watchdog expiry on the same slot.
    if (rsp_ok) state_d[rsp_idx] = mem_resp_nack_i ? ISSUE : FREE;

    ptr_d           = issue_hs ? gnt_idx + IW'(1) : ptr_q;
    hold_d          = mem_req_valid_o & ~mem_req_ready_i;
    hold_idx_d      = gnt_idx;
    err_d           = err_q | rsp_stray | (|tmo_hit);
    resp_vld_d      = rsp_ok & ~mem_resp_nack_i;
    resp_tag_d      = slot_q[rsp_idx].tag;
    resp_data_d     = mem_resp_data_i;
    resp_has_data_d = mem_resp_has_data_i;
  end

  // Control registers: reset drops every in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= FREE;
      ptr_q      <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      err_q      <= 1'b0;
      resp_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) state_q[i] <= state_d[i];
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      err_q      <= err_d;
      resp_vld_q <= resp_vld_d;
    end
  end

  // Payload registers carry no reset; their outputs are qualified by valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) slot_q[i] <= slot_d[i];
    resp_tag_q      <= resp_tag_d;
    resp_data_q     <= resp_data_d;
    resp_has_data_q <= resp_has_data_d;
  end

  assign acc_req_ready_o     = |free_vec;
  assign busy_o              = |busy_vec;
  assign err_o               = err_q;

  assign mem_req_valid_o     = |issue_vec;
  assign mem_req_addr_o      = mem_req_valid_o ? slot_q[gnt_idx].addr : '0;
  assign mem_req_tag_o       = mem_req_valid_o ? {{(TAG_W - IW){1'b0}}, gnt_idx} : '0;
  assign mem_req_cmd_o       = mem_req_valid_o ? slot_q[gnt_idx].cmd : '0;
  assign mem_req_typ_o       = mem_req_valid_o ? slot_q[gnt_idx].typ : '0;
  assign mem_req_data_o      = mem_req_valid_o ? slot_q[gnt_idx].data : '0;
  assign mem_req_phys_o      = 1'b0;

  assign acc_resp_valid_o    = resp_vld_q;
  assign acc_resp_tag_o      = resp_vld_q ? resp_tag_q : '0;
  assign acc_resp_data_o     = resp_vld_q ? resp_data_q : '0;
  assign acc_resp_has_data_o = resp_vld_q & resp_has_data_q;

endmodule

// File: tb/tb_rocc_mem_retry_queue.sv
// Directed bench for rocc_mem_retry_queue (NUM_ENTRIES = 4, TIMEOUT_CYCLES = 16).
module tb_rocc_mem_retry_queue;
  import rocc_mem_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              acc_req_valid_i, acc_req_ready_o;
  logic [ADDR_W-1:0] acc_req_addr_i;
  logic [TAG_W-1:0]  acc_req_tag_i;
  logic [CMD_W-1:0]  acc_req_cmd_i;
  logic [TYP_W-1:0]  acc_req_typ_i;
  logic [DATA_W-1:0] acc_req_data_i;
  logic              acc_resp_valid_o, acc_resp_has_data_o;
  logic [TAG_W-1:0]  acc_resp_tag_o;
  logic [DATA_W-1:0] acc_resp_data_o;
  logic              mem_req_ready_i, mem_req_valid_o, mem_req_phys_o;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic [TAG_W-1:0]  mem_req_tag_o;
  logic [CMD_W-1:0]  mem_req_cmd_o;
  logic [TYP_W-1:0]  mem_req_typ_o;
  logic [DATA_W-1:0] mem_req_data_o;
  logic              mem_resp_valid_i, mem_resp_has_data_i, mem_resp_nack_i;
  logic [TAG_W-1:0]  mem_resp_tag_i;
  logic [DATA_W-1:0] mem_resp_data_i;
  logic              busy_o, err_o;

  always #5 clk = ~clk;

  rocc_mem_retry_queue #(.NUM_ENTRIES(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .acc_req_valid_i(acc_req_valid_i), .acc_req_ready_o(acc_req_ready_o),
    .acc_req_addr_i(acc_req_addr_i), .acc_req_tag_i(acc_req_tag_i),
    .acc_req_cmd_i(acc_req_cmd_i), .acc_req_typ_i(acc_req_typ_i),
    .acc_req_data_i(acc_req_data_i),
    .acc_resp_valid_o(acc_resp_valid_o), .acc_resp_tag_o(acc_resp_tag_o),
    .acc_resp_data_o(acc_resp_data_o), .acc_resp_has_data_o(acc_resp_has_data_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_tag_o(mem_req_tag_o),
    .mem_req_cmd_o(mem_req_cmd_o), .mem_req_typ_o(mem_req_typ_o),
    .mem_req_data_o(mem_req_data_o), .mem_req_phys_o(mem_req_phys_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_tag_i(mem_resp_tag_i),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_has_data_i(mem_resp_has_data_i),
    .mem_resp_nack_i(mem_resp_nack_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        av;   logic [39:0] aaddr; logic [9:0] atag; logic [4:0] acmd; logic [63:0] adata;
    logic        mrdy; logic rv; logic [9:0] rtag; logic [63:0] rdata; logic rhd; logic nack;
    logic        e_ardy; logic e_mv; logic [9:0] e_mtag; logic [39:0] e_maddr; logic [63:0] e_mdata;
    logic        e_rv; logic [9:0] e_rtag; logic [63:0] e_rdata; logic e_rhd; logic e_busy; logic e_err;
  } vec_t;

  function automatic vec_t vr(
      input logic av, input logic [39:0] aaddr, input logic [9:0] atag, input logic [4:0] acmd,
      input logic [63:0] adata, input logic mrdy, input logic rv, input logic [9:0] rtag,
      input logic [63:0] rdata, input logic rhd, input logic nack,
      input logic e_ardy, input logic e_mv, input logic [9:0] e_mtag, input logic [39:0] e_maddr,
      input logic [63:0] e_mdata, input logic e_rv, input logic [9:0] e_rtag,
      input logic [63:0] e_rdata, input logic e_rhd, input logic e_busy, input logic e_err);
    vec_t v;
    v.av = av; v.aaddr = aaddr; v.atag = atag; v.acmd = acmd; v.adata = adata;
    v.mrdy = mrdy; v.rv = rv; v.rtag = rtag; v.rdata = rdata; v.rhd = rhd; v.nack = nack;
    v.e_ardy = e_ardy; v.e_mv = e_mv; v.e_mtag = e_mtag; v.e_maddr = e_maddr; v.e_mdata = e_mdata;
    v.e_rv = e_rv; v.e_rtag = e_rtag; v.e_rdata = e_rdata; v.e_rhd = e_rhd;
    v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic idle();
    acc_req_valid_i = 0; acc_req_addr_i = '0; acc_req_tag_i = '0; acc_req_cmd_i = '0;
    acc_req_typ_i = 3'd3; acc_req_data_i = '0; mem_req_ready_i = 0;
    mem_resp_valid_i = 0; mem_resp_tag_i = '0; mem_resp_data_i = '0;
    mem_resp_has_data_i = 0; mem_resp_nack_i = 0;
  endtask

  vec_t vecs[$];

  initial begin
    // Single-slot scenarios: load, nacked store, nack+valid, stray responses.
    vecs.push_back(vr(1,'h1000,'h2A,M_XRD,0,     0, 0,0,0,0,0,       1,0,0,0,0,         0,0,0,0,          0,0));
    vecs.push_back(vr(0,0,0,0,0,                 1, 0,0,0,0,0,       1,1,0,'h1000,0,    0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 1,0,'hDEAD,1,0,  1,0,0,0,0,         0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 0,0,0,0,0,       1,0,0,0,0,         1,'h2A,'hDEAD,1,  0,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 0,0,0,0,0,       1,0,0,0,0,         0,0,0,0,          0,0));
    vecs.push_back(vr(1,'h2000,'h11,M_XWR,'h55,  0, 0,0,0,0,0,       1,0,0,0,0,         0,0,0,0,          0,0));
    vecs.push_back(vr(0,0,0,0,0,                 1, 0,0,0,0,0,       1,1,0,'h2000,'h55, 0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 0,0,0,0,1,       1,0,0,0,0,         0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 1, 0,0,0,0,0,       1,1,0,'h2000,'h55, 0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 1,0,0,0,0,       1,0,0,0,0,         0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 0,0,0,0,0,       1,0,0,0,0,         1,'h11,0,0,       0,0));
    vecs.push_back(vr(1,'h3000,'h33,M_XRD,0,     0, 0,0,0,0,0,       1,0,0,0,0,         0,0,0,0,          0,0));
    vecs.push_back(vr(0,0,0,0,0,                 1, 0,0,0,0,0,       1,1,0,'h3000,0,    0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 1,0,'hBAD,1,1,   1,0,0,0,0,         0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 0,0,0,0,0,       1,1,0,'h3000,0,    0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 1, 0,0,0,0,0,       1,1,0,'h3000,0,    0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 1,0,'h1234,1,0,  1,0,0,0,0,         0,0,0,0,          1,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 0,0,0,0,0,       1,0,0,0,0,         1,'h33,'h1234,1,  0,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 1,1,0,0,0,       1,0,0,0,0,         0,0,0,0,          0,0));
    vecs.push_back(vr(0,0,0,0,0,                 0, 0,0,0,0,0,       1,0,0,0,0,         0,0,0,0,          0,1));
    vecs.push_back(vr(0,0,0,0,0,                 0, 1,7,'h77,1,0,    1,0,0,0,0,         0,0,0,0,          0,1));
    vecs.push_back(vr(0,0,0,0,0,                 0, 0,0,0,0,0,       1,0,0,0,0,         0,0,0,0,          0,1));

    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0; #1;
    chk("rst_ready", acc_req_ready_o, 1);
    chk("rst_resp_valid", acc_resp_valid_o, 0);
    chk("rst_resp_tag", acc_resp_tag_o, 0);
    chk("rst_resp_data", acc_resp_data_o, 0);
    chk("rst_resp_hd", acc_resp_has_data_o, 0);
    chk("rst_mem_valid", mem_req_valid_o, 0);
    chk("rst_mem_addr", mem_req_addr_o, 0);
    chk("rst_mem_tag", mem_req_tag_o, 0);
    chk("rst_mem_cmd", mem_req_cmd_o, 0);
    chk("rst_mem_typ", mem_req_typ_o, 0);
    chk("rst_mem_data", mem_req_data_o, 0);
    chk("rst_mem_phys", mem_req_phys_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      acc_req_valid_i = vecs[i].av; acc_req_addr_i = vecs[i].aaddr; acc_req_tag_i = vecs[i].atag;
      acc_req_cmd_i = vecs[i].acmd; acc_req_data_i = vecs[i].adata; mem_req_ready_i = vecs[i].mrdy;
      mem_resp_valid_i = vecs[i].rv; mem_resp_tag_i = vecs[i].rtag; mem_resp_data_i = vecs[i].rdata;
      mem_resp_has_data_i = vecs[i].rhd; mem_resp_nack_i = vecs[i].nack;
      #1;
      chk($sformatf("v%0d_ready", i), acc_req_ready_o, vecs[i].e_ardy);
      chk($sformatf("v%0d_mem_valid", i), mem_req_valid_o, vecs[i].e_mv);
      chk($sformatf("v%0d_resp_valid", i), acc_resp_valid_o, vecs[i].e_rv);
      chk($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
      chk($sformatf("v%0d_err", i), err_o, vecs[i].e_err);
      if (vecs[i].e_mv) begin
        chk($sformatf("v%0d_mem_tag", i), mem_req_tag_o, vecs[i].e_mtag);
        chk($sformatf("v%0d_mem_addr", i), mem_req_addr_o, vecs[i].e_maddr);
        chk($sformatf("v%0d_mem_data", i), mem_req_data_o, vecs[i].e_mdata);
      end
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d_resp_tag", i), acc_resp_tag_o, vecs[i].e_rtag);
        chk($sformatf("v%0d_resp_data", i), acc_resp_data_o, vecs[i].e_rdata);
        chk($sformatf("v%0d_resp_hd", i), acc_resp_has_data_o, vecs[i].e_rhd);
      end
    end

    // Fill all four slots with the cache stalled.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle();
      acc_req_valid_i = 1; acc_req_addr_i = 40'h4000 + 40'(k * 'h40);
      acc_req_tag_i = 10'h40 + 10'(k); acc_req_data_i = 64'hA0 + 64'(k); #1;
      chk($sformatf("fill%0d_ready", k), acc_req_ready_o, 1);
    end
    @(negedge clk);
    acc_req_addr_i = 40'h5000; acc_req_tag_i = 10'h44; acc_req_data_i = 64'hA4; #1;
    chk("full_ready", acc_req_ready_o, 0);
    chk("full_busy", busy_o, 1);

    // Round-robin grant order with mem_req_ready_i toggling; payload held while stalled.
    for (int g = 0; g < 4; g++) begin
      @(negedge clk); mem_req_ready_i = 0; #1;
      chk($sformatf("rr%0d_stall_valid", g), mem_req_valid_o, 1);
      chk($sformatf("rr%0d_stall_tag", g), mem_req_tag_o, g);
      chk($sformatf("rr%0d_stall_addr", g), mem_req_addr_o, 40'h4000 + 40'(g * 'h40));
      @(negedge clk); mem_req_ready_i = 1; #1;
      chk($sformatf("rr%0d_tag", g), mem_req_tag_o, g);
      chk($sformatf("rr%0d_addr", g), mem_req_addr_o, 40'h4000 + 40'(g * 'h40));
      chk($sformatf("rr%0d_data", g), mem_req_data_o, 64'hA0 + 64'(g));
    end

    // All WAIT: an out-of-range tag aliasing slot 2 must be ignored.
    @(negedge clk); mem_req_ready_i = 0;
    mem_resp_valid_i = 1; mem_resp_tag_i = 10'd6; mem_resp_data_i = 64'h66; mem_resp_has_data_i = 1; #1;
    chk("allwait_mem_valid", mem_req_valid_o, 0);
    @(negedge clk); mem_resp_valid_i = 0; #1;
    chk("oor_no_resp", acc_resp_valid_o, 0);
    chk("oor_still_full", acc_req_ready_o, 0);

    // Response to slot 2 frees it; the pending 5th request lands there.
    @(negedge clk);
    mem_resp_valid_i = 1; mem_resp_tag_i = 10'd2; mem_resp_data_i = 64'h22; mem_resp_has_data_i = 1; #1;
    chk("resp2_same_cycle_ready", acc_req_ready_o, 0);
    @(negedge clk); mem_resp_valid_i = 0; #1;
    chk("resp2_valid", acc_resp_valid_o, 1);
    chk("resp2_tag", acc_resp_tag_o, 10'h42);
    chk("resp2_data", acc_resp_data_o, 64'h22);
    chk("resp2_ready", acc_req_ready_o, 1);
    @(negedge clk); acc_req_valid_i = 0; #1;
    chk("fifth_ready", acc_req_ready_o, 0);
    chk("fifth_mem_valid", mem_req_valid_o, 1);
    chk("fifth_slot", mem_req_tag_o, 2);
    chk("fifth_addr", mem_req_addr_o, 40'h5000);
    chk("err_sticky", err_o, 1);

    // Reset with three slots in WAIT and a response arriving in the same cycle.
    @(negedge clk); rst = 1;
    mem_resp_valid_i = 1; mem_resp_tag_i = 10'd0; mem_resp_data_i = 64'h99; mem_resp_has_data_i = 1;
    @(negedge clk); rst = 0; idle(); #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", acc_req_ready_o, 1);
    chk("midrst_resp_valid", acc_resp_valid_o, 0);
    chk("midrst_mem_valid", mem_req_valid_o, 0);
    chk("midrst_err", err_o, 0);
    @(negedge clk); #1;
    chk("midrst_resp_valid2", acc_resp_valid_o, 0);

`ifdef MEM_RETRY_TIMEOUT_EN
    begin
      int  k;
      bit  seen;
      @(negedge clk); acc_req_valid_i = 1; acc_req_addr_i = 40'h6000; acc_req_tag_i = 10'h66;
      @(negedge clk); idle(); mem_req_ready_i = 1; #1;
      chk("tmo_first_issue", mem_req_valid_o, 1);
      k = 0; seen = 0;
      while (!seen && k < 40) begin
        @(negedge clk); mem_req_ready_i = 0; k++; #1;
        if (mem_req_valid_o) seen = 1;
      end
      chk("tmo_reissue_cycle", k, 17);
      chk("tmo_reissue_addr", mem_req_addr_o, 40'h6000);
      chk("tmo_err", err_o, 1);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
